// File: rtl/uart_print_fifo.sv
// uart_print_fifo
//   Byte FIFO between the core print port and an 8-bit UART transmitter.
//   Print writes are absorbed at core speed and drained one byte at a time
//   through a start/busy/done handshake. Fill level and a sticky overflow
//   flag with a saturating drop counter are reported for software/LEDs.
//
// Ports
//   clk_i          clock (shared with the UART)
//   rst_ni         asynchronous active-low reset
//   print_valid_i  one-cycle write strobe; print_wdata_i[7:0] is the byte
//   tx_start_o     one-cycle start pulse to the UART
//   tx_data_o      byte to the UART, stable from start until done
//   tx_busy_i      UART transmitting
//   tx_done_i      UART finished a byte (pulse)
//   empty_o/full_o/level_o   occupancy, derived from the registered pointers
//   overflow_o     sticky, set on the first dropped byte
//   drop_count_o   saturating count of dropped bytes
//
// Optional build macro
//   UART_PRINT_CRLF_EN : a popped 8'h0A is sent as 8'h0D followed by 8'h0A
//                        (the 8'h0A is replayed from a flag, not re-popped).
module uart_print_fifo #(
   parameter int DEPTH      = 16,
   parameter int DROP_CNT_W = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    print_valid_i,
   input  logic [31:0]             print_wdata_i,
   output logic                    tx_start_o,
   output logic [7:0]              tx_data_o,
   input  logic                    tx_busy_i,
   input  logic                    tx_done_i,
   output logic                    empty_o,
   output logic                    full_o,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic                    overflow_o,
   output logic [DROP_CNT_W-1:0]   drop_count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0]         PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3
`ifdef UART_PRINT_CRLF_EN
      ,
      ST_CR_PEND   = 3'd4
`endif
   } state_e;

   state_e                  state_r;
   state_e                  state_s;
   state_e                  fin_state_s;
   logic [7:0]              mem_r [DEPTH];
   logic [PW-1:0]           wr_ptr_r;
   logic [PW-1:0]           rd_ptr_r;
   logic [7:0]              tx_data_r;
   logic                    tx_start_r;
   logic                    overflow_r;
   logic [DROP_CNT_W-1:0]   drop_cnt_r;
   logic                    empty_s;
   logic                    full_s;
   logic [7:0]              head_s;
   logic                    pop_s;
   logic                    push_s;
   logic                    drop_s;
   logic                    load_s;
   logic [7:0]              load_data_s;
   logic                    unused_wdata_s;
`ifdef UART_PRINT_CRLF_EN
   logic                    lf_pend_r;
   logic                    set_lf_s;
   logic                    clr_lf_s;
`endif

   assign unused_wdata_s = ^print_wdata_i[31:8];

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   // Extra pointer MSB distinguishes full from empty when the slot indices match.
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

   // A pop frees a slot in the same cycle, so a push while full is still accepted then.
   assign push_s  = print_valid_i && (!full_s || pop_s);
   assign drop_s  = print_valid_i && full_s && !pop_s;

   assign tx_start_o   = tx_start_r;
   assign tx_data_o    = tx_data_r;
   assign empty_o      = empty_s;
   assign full_o       = full_s;
   assign level_o      = wr_ptr_r - rd_ptr_r;
   assign overflow_o   = overflow_r;
   assign drop_count_o = drop_cnt_r;

   // Where the FSM goes once the UART has finished the current byte.
   always_comb begin
      fin_state_s = ST_IDLE;
`ifdef UART_PRINT_CRLF_EN
      if (lf_pend_r) begin
         fin_state_s = ST_CR_PEND;
      end else begin
         fin_state_s = ST_IDLE;
      end
`endif
   end

   // Next-state and handshake decode.
   always_comb begin
      state_s     = state_r;
      pop_s       = 1'b0;
      load_s      = 1'b0;
      load_data_s = head_s;
`ifdef UART_PRINT_CRLF_EN
      set_lf_s    = 1'b0;
      clr_lf_s    = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (!empty_s && !tx_busy_i) begin
               pop_s   = 1'b1;
               load_s  = 1'b1;
               state_s = ST_START;
`ifdef UART_PRINT_CRLF_EN
               if (head_s == 8'h0A) begin
                  load_data_s = 8'h0D;
                  set_lf_s    = 1'b1;
               end else begin
                  load_data_s = head_s;
               end
`endif
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            state_s = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_s = ST_WAIT_DONE;
            end else if (tx_done_i) begin
               // UART finished without a visible busy cycle.
               state_s = fin_state_s;
            end else begin
               state_s = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done_i || !tx_busy_i) begin
               state_s = fin_state_s;
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
`ifdef UART_PRINT_CRLF_EN
         ST_CR_PEND: begin
            // Replay the LF that triggered the CR, without touching the FIFO.
            if (!tx_busy_i) begin
               load_s      = 1'b1;
               load_data_s = 8'h0A;
               clr_lf_s    = 1'b1;
               state_s     = ST_START;
            end else begin
               state_s = ST_CR_PEND;
            end
         end
`endif
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FIFO storage; pointers define validity, so the array itself needs no reset.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= print_wdata_i[7:0];
      end
   end

   // Read/write pointers, wrapping naturally modulo 2*DEPTH.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // UART-facing outputs; data only changes when a new byte is launched.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_start_r <= 1'b0;
         tx_data_r  <= 8'h00;
      end else begin
         tx_start_r <= (state_s == ST_START);
         if (load_s) begin
            tx_data_r <= load_data_s;
         end
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= {DROP_CNT_W{1'b0}};
      end else if (drop_s) begin
         overflow_r <= 1'b1;
         if (drop_cnt_r != DROP_MAX) begin
            drop_cnt_r <= drop_cnt_r + DROP_ONE;
         end
      end
   end

`ifdef UART_PRINT_CRLF_EN
   // Remembers that an LF still has to follow the CR currently on the wire.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lf_pend_r <= 1'b0;
      end else if (set_lf_s) begin
         lf_pend_r <= 1'b1;
      end else if (clr_lf_s) begin
         lf_pend_r <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_print_fifo.sv
// Testbench for uart_print_fifo: directed sequences, a table of overflow
// vectors and randomized traffic, all checked against a queue-based model
// and a simple UART TX responder.
module tb_uart_print_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          print_valid_i;
   logic [31:0]   print_wdata_i;
   logic          tx_start_o;
   logic [7:0]    tx_data_o;
   logic          tx_busy_i;
   logic          tx_done_i;
   logic          empty_o;
   logic          full_o;
   logic [4:0]    level_o;
   logic          overflow_o;
   logic [DW-1:0] drop_count_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   uart_print_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .print_valid_i(print_valid_i), .print_wdata_i(print_wdata_i),
      .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
      .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i),
      .empty_o(empty_o), .full_o(full_o), .level_o(level_o),
      .overflow_o(overflow_o), .drop_count_o(drop_count_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- UART TX responder ----------------
   logic busy_m = 1'b0, done_m = 1'b0, hold_busy = 1'b0;
   bit   u_active = 1'b0, rand_lat = 1'b0;
   int   u_timer = 0, busy_lat = 1, done_lat = 100;
   logic [7:0] last_tx = 8'h00;

   assign tx_busy_i = busy_m | hold_busy;
   assign tx_done_i = done_m;

   always @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_m = 1'b0; done_m = 1'b0; u_active = 1'b0; u_timer = 0;
      end else begin
         done_m = 1'b0;
         if (tx_start_o) begin
            check("no_overlap", 32'(u_active), 32'd0);
            u_active = 1'b1; u_timer = 0; last_tx = tx_data_o;
            if (rand_lat) begin
               busy_lat = $urandom_range(0, 2);
               done_lat = $urandom_range(1, 12);
            end
         end else if (u_active) begin
            check("tx_data_hold", 32'(tx_data_o), 32'(last_tx));
            u_timer++;
            if (busy_lat != 0 && u_timer == busy_lat) busy_m = 1'b1;
            if (u_timer >= busy_lat + done_lat) begin
               busy_m = 1'b0; done_m = 1'b1; u_active = 1'b0;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0]    ref_q[$];
   bit            ref_ovf = 1'b0;
   logic [DW-1:0] ref_drop = '0;
   bit            lf_pend = 1'b0;
   int            n_starts = 0;
   logic [7:0]    last_popped = 8'h00;

   task automatic model_reset();
      ref_q.delete(); ref_ovf = 1'b0; ref_drop = '0; lf_pend = 1'b0;
   endtask

   // Advance the model by one clock: a start pulse now visible means a byte
   // left the queue at the edge just passed; the push was offered at that edge.
   task automatic model_update(input logic v, input logic [7:0] d);
      bit was_full, popped;
      logic [7:0] b, exp;
      was_full = (ref_q.size() == DEPTH);
      popped = 1'b0;
      if (tx_start_o) begin
         n_starts++;
         if (lf_pend) begin
            check("crlf_lf", 32'(tx_data_o), 32'h0A);
            lf_pend = 1'b0;
         end else if (ref_q.size() == 0) begin
            check("start_when_empty", 32'(tx_start_o), 32'd0);
         end else begin
            b = ref_q.pop_front();
            popped = 1'b1;
            last_popped = b;
            exp = b;
`ifdef UART_PRINT_CRLF_EN
            if (b == 8'h0A) begin exp = 8'h0D; lf_pend = 1'b1; end
`endif
            check("tx_data", 32'(tx_data_o), 32'(exp));
         end
      end
      if (v) begin
         if (was_full && !popped) begin
            ref_ovf = 1'b1;
            if (ref_drop != {DW{1'b1}}) ref_drop++;
         end else begin
            ref_q.push_back(d);
         end
      end
      check("level", 32'(level_o), ref_q.size());
      check("empty", 32'(empty_o), 32'(ref_q.size() == 0));
      check("full", 32'(full_o), 32'(ref_q.size() == DEPTH));
      check("overflow", 32'(overflow_o), 32'(ref_ovf));
      check("drop_count", 32'(drop_count_o), 32'(ref_drop));
   endtask

   task automatic cycle(input logic v, input logic [7:0] d);
      logic [31:0] r;
      r = $urandom;
      print_valid_i = v;
      print_wdata_i = {r[31:8], d};
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      print_valid_i = 1'b0;
      model_update(v, d);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((ref_q.size() != 0 || u_active || lf_pend) && n < budget) begin
         cycle(1'b0, 8'h00);
         n++;
      end
      if (n >= budget) begin
         errors++; checks++;
         $display("FAIL drain_timeout: got %0d pending expected 0", ref_q.size());
      end else begin
         checks++;
      end
      repeat (3) cycle(1'b0, 8'h00);
   endtask

   typedef struct {
      logic          v;
      logic [7:0]    d;
      logic [4:0]    level;
      logic          full;
      logic          ovf;
      logic [DW-1:0] drop;
   } vec_t;
   vec_t tbl[19];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      for (int i = 0; i < 19; i++) begin
         tbl[i].v     = 1'b1;
         tbl[i].d     = 8'(8'h80 + i);
         tbl[i].level = (i < 16) ? 5'(i + 1) : 5'd16;
         tbl[i].full  = (i >= 15);
         tbl[i].ovf   = (i >= 16);
         tbl[i].drop  = (i >= 16) ? DW'(i - 15) : '0;
      end

      rst_ni = 1'b0; print_valid_i = 1'b0; print_wdata_i = 32'h0;
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_start", 32'(tx_start_o), 32'd0);
      check("rst_data", 32'(tx_data_o), 32'h00);
      check("rst_level", 32'(level_o), 32'd0);
      check("rst_empty", 32'(empty_o), 32'd1);
      check("rst_full", 32'(full_o), 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      check("rst_drop", 32'(drop_count_o), 32'd0);
      rst_ni = 1'b1;
      cycle(1'b0, 8'h00);

      // Single byte: start appears two cycles after the push edge.
      s0 = n_starts;
      cycle(1'b1, 8'h41);
      check("single_no_early_start", 32'(tx_start_o), 32'd0);
      cycle(1'b0, 8'h00);
      check("single_start", 32'(tx_start_o), 32'd1);
      check("single_data", 32'(tx_data_o), 32'h41);
      check("single_empty", 32'(empty_o), 32'd1);
      drain(300);
      check("single_count", n_starts - s0, 32'd1);

      // Burst of 16 with the UART held busy, then drained in order.
      busy_lat = 1; done_lat = 3;
      hold_busy = 1'b1;
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i));
      check("burst_full", 32'(full_o), 32'd1);
      check("burst_no_ovf", 32'(overflow_o), 32'd0);
      hold_busy = 1'b0;
      drain(500);
      check("burst_ovf_after", 32'(overflow_o), 32'd0);

      // Overflow: table of pushes against a held-busy UART.
      hold_busy = 1'b1;
      for (int i = 0; i < 19; i++) begin
         cycle(tbl[i].v, tbl[i].d);
         check("tbl_level", 32'(level_o), 32'(tbl[i].level));
         check("tbl_full", 32'(full_o), 32'(tbl[i].full));
         check("tbl_ovf", 32'(overflow_o), 32'(tbl[i].ovf));
         check("tbl_drop", 32'(drop_count_o), 32'(tbl[i].drop));
      end
      hold_busy = 1'b0;
      drain(500);
      check("ovf_last_byte", 32'(last_popped), 32'h8F);
      check("ovf_sticky", 32'(overflow_o), 32'd1);

      // Push coinciding with the pop while full.
      hold_busy = 1'b1;
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i));
      hold_busy = 1'b0;
      cycle(1'b1, 8'hAA);
      check("ppf_start", 32'(tx_start_o), 32'd1);
      check("ppf_level", 32'(level_o), 32'd16);
      check("ppf_drop", 32'(drop_count_o), 32'd3);
      drain(600);
      check("ppf_last", 32'(last_popped), 32'hAA);

`ifdef UART_PRINT_CRLF_EN
      s0 = n_starts;
      cycle(1'b1, 8'h0A);
      check("crlf_level1", 32'(level_o), 32'd1);
      cycle(1'b0, 8'h00);
      check("crlf_cr", 32'(tx_data_o), 32'h0D);
      check("crlf_level0", 32'(level_o), 32'd0);
      drain(300);
      check("crlf_starts", n_starts - s0, 32'd2);
`endif

      // Reset in the middle of a transfer with 5 bytes queued.
      busy_lat = 1; done_lat = 30;
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h50 + i));
      repeat (3) cycle(1'b0, 8'h00);
      check("mid_level", 32'(level_o), 32'd5);
      check("mid_busy", 32'(u_active), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_start", 32'(tx_start_o), 32'd0);
      check("mid_rst_data", 32'(tx_data_o), 32'h00);
      check("mid_rst_level", 32'(level_o), 32'd0);
      check("mid_rst_empty", 32'(empty_o), 32'd1);
      check("mid_rst_ovf", 32'(overflow_o), 32'd0);
      check("mid_rst_drop", 32'(drop_count_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      #1;
      rst_ni = 1'b1;
      s0 = n_starts;
      repeat (20) cycle(1'b0, 8'h00);
      check("mid_no_start", n_starts - s0, 32'd0);

      // Randomized traffic with a randomized UART.
      rand_lat = 1'b1;
      for (int i = 0; i < 1200; i++) begin
         int rate;
         rate = ((i / 150) % 2 == 0) ? 70 : 10;
         cycle(($urandom_range(0, 99) < rate), 8'($urandom_range(0, 255)));
      end
      drain(2000);
      check("rand_end_empty", 32'(empty_o), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_print_fifo.md
Name: uart_print_fifo

Overview:
- Byte buffer between the core subsystem's print port (print_valid/print_wdata) and the 8-bit UART transmitter.
- Absorbs back-to-back print writes from the core, which arrive far faster than the UART baud rate.
- Drains bytes one at a time using a start/busy/done handshake with the UART TX.
- Reports fill level and overflow so software or an LED can detect lost characters.

Parameters:
- DEPTH, 16, FIFO entries. Power of two, >= 2.
- DROP_CNT_W, 16, width of the saturating dropped-byte counter.

Ports:
- clk_i  in  1  clock; same clock as the UART.
- rst_ni  in  1  asynchronous active-low reset.
- print_valid_i  in  1  one-cycle write strobe from the core.
- print_wdata_i  in  32  print data; only bits [7:0] are used.
- tx_start_o  out  1  one-cycle start pulse to the UART TX.
- tx_data_o  out  8  byte to the UART; held stable from the start pulse until done.
- tx_busy_i  in  1  UART is transmitting.
- tx_done_i  in  1  UART finished a byte (pulse).
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky; set on the first dropped byte.
- drop_count_o  out  DROP_CNT_W  number of dropped bytes; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - Pointers are 0, level_o=0, empty_o=1, full_o=0.
  - tx_start_o=0, tx_data_o=8'h00.
  - overflow_o=0, drop_count_o=0.
  - FSM is in IDLE.
- Storage: circular buffer with $clog2(DEPTH)+1-bit read/write pointers.
  - Pointers wrap modulo 2*DEPTH.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Push: print_valid_i=1 and the FIFO is not full. print_wdata_i[7:0] is written at the write pointer, which then increments.
- Overflow: print_valid_i=1 while full and no pop happens in the same cycle.
  - The byte is dropped.
  - overflow_o is set to 1.
  - drop_count_o increments, saturating.
- Simultaneous push and pop while full: the push is accepted and level_o is unchanged.
- Simultaneous push and pop while empty cannot occur, because a pop requires a non-empty FIFO.
- Pop: occurs only on the IDLE->START transition described below.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE:
    - If the FIFO is not empty and tx_busy_i=0, latch the head byte into tx_data_o, pop it, and go to START.
    - Otherwise stay in IDLE.
  - START: tx_start_o=1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy_i=1 -> WAIT_DONE.
    - tx_done_i=1 -> IDLE (handles a UART that completes without a visible busy cycle).
  - WAIT_DONE: tx_done_i=1, or tx_busy_i falling to 0 -> IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with the UART idle produces tx_start_o=1 in cycle N+2.
  - Edge N+1: IDLE->START.
  - Cycle N+2: tx_start_o is asserted.
- Throughput: at most one byte in flight. A new start is never issued before the previous done/busy-low is observed.
- Output stability: tx_data_o changes only on the IDLE->START transition.
- level_o, empty_o, full_o are registered-pointer derived and reflect the state after the previous edge.
- Reset mid-transmission: the FSM returns to IDLE and FIFO contents are discarded. Any partial UART frame is the UART's responsibility.
- Only a reset clears the overflow state (overflow_o and drop_count_o).

Optional Feature:
- Macro: UART_PRINT_CRLF_EN.
- Defined:
  - When the popped byte is 8'h0A, the block first sends 8'h0D through a full START/WAIT_BUSY/WAIT_DONE cycle.
  - It then sends 8'h0A without a second pop.
  - Implemented with an extra state CR_PEND and a 1-bit flag. The flag is cleared on reset.
- Not defined: bytes are sent verbatim and CR_PEND logic is absent.

Test Plan:
- Single byte:
  - Stimulus: push 8'h41 into an empty FIFO; UART model raises busy 1 cycle after start and pulses done 100 cycles later.
  - Response: exactly one tx_start_o pulse with tx_data_o=8'h41, 2 cycles after the push. empty_o=1 after the pop; FSM back in IDLE after done.
- Burst:
  - Stimulus: push 8'h00..8'h0F on 16 consecutive cycles with DEPTH=16.
  - Response: full_o=1 after the 16th push; the bytes are transmitted in order 00..0F; overflow_o stays 0.
- Overflow:
  - Stimulus: fill the FIFO with the UART held busy, then push 3 more bytes.
  - Response: overflow_o=1, drop_count_o=3, level_o=16. The stored bytes are unchanged and drain in order.
- Push/pop while full:
  - Stimulus: FIFO full, and a push coincides with the IDLE->START pop.
  - Response: level_o stays 16, drop_count_o is unchanged, and the pushed byte is later transmitted last.
- Reset mid-operation:
  - Stimulus: assert rst_ni low during WAIT_DONE with 5 bytes queued.
  - Response: outputs go immediately to their reset values. After release there is no tx_start_o, empty_o=1 and level_o=0.
- CRLF (UART_PRINT_CRLF_EN defined):
  - Stimulus: push 8'h0A.
  - Response: two start pulses with tx_data_o=8'h0D then 8'h0A; level_o goes from 1 to 0 on the first pop only.
